// File: rtl/clkdlx1_if.sv
// clkdlx1_if: enable inputs and gated-clock outputs of the clock-gating cell.
// The parent clock and reset stay plain scalar ports on the cell itself.
interface clkdlx1_if;
  logic E;
  logic SE;
  logic ECK;
  logic EQ;

  // Driver side: supplies the enables and observes the gated clock
  modport master (
    output E,
    output SE,
    input  ECK,
    input  EQ
  );

  // Cell side: consumes the enables and produces the gated clock
  modport slave (
    input  E,
    input  SE,
    output ECK,
    output EQ
  );
endinterface

// File: rtl/clkdlx1.sv
// clkdlx1: latch-based integrated clock-gating cell.
// The enable (E | SE) is held across each high phase of CK so that the gated
// clock ECK = CK & held_enable only ever passes complete CK high phases.
// FPGA_MODE = 0 holds the enable in a low-transparent latch; FPGA_MODE = 1
// uses a falling-edge flop, which is cycle-equivalent whenever E/SE are
// driven from the rising edge of CK.
module clkdlx1 #(
  parameter bit FPGA_MODE = 1'b0
) (
  input  logic      CK,
  input  logic      RST,
  clkdlx1_if.slave  bus
);

  logic en_d;
  logic en_q;

  // Effective enable: functional enable or scan override
  always_comb begin
    en_d = bus.E | bus.SE;
  end

  generate
    if (FPGA_MODE == 1'b0) begin : g_latch
      // Transparent while CK is low, closed through the high phase; reset clears it asynchronously
      always_latch begin
        if (RST) begin
          en_q <= 1'b0;
        end else if (!CK) begin
          en_q <= en_d;
        end
      end
    end else begin : g_flop
      // Capture on the falling edge so the value is stable for the whole high phase
      always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
          en_q <= 1'b0;
        end else begin
          en_q <= en_d;
        end
      end
    end
  endgenerate

  assign bus.ECK = CK & en_q;
  assign bus.EQ  = en_q;

endmodule

// File: tb/tb_clkdlx1.sv
// tb_clkdlx1: directed bench for the clock-gating cell.
// Instance A (latch mode) and instance B (flop mode) see identical stimulus and
// are held to the same expected waveform; instance C is clocked by A's ECK with
// a divide-by-2 enable to exercise cascading.
module tb_clkdlx1;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       e_drv = 1'b0;
  logic       se_drv = 1'b0;
  logic       div_mode = 1'b0;
  logic [3:0] div_cnt = 4'd0;
  logic       tog_clr = 1'b1;
  logic       tog = 1'b0;

  int checks = 0;
  int errors = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int cnt_c = 0;
  int base_a;
  int base_b;
  int base_c;

  clkdlx1_if if_a ();
  clkdlx1_if if_b ();
  clkdlx1_if if_c ();

  clkdlx1 #(.FPGA_MODE(1'b0)) u_a (.CK(ck),       .RST(rst), .bus(if_a.slave));
  clkdlx1 #(.FPGA_MODE(1'b1)) u_b (.CK(ck),       .RST(rst), .bus(if_b.slave));
  clkdlx1 #(.FPGA_MODE(1'b0)) u_c (.CK(if_a.ECK), .RST(rst), .bus(if_c.slave));

  // Parent clock, 10 ns period
  always #5 ck = ~ck;

  // Divide-by-12 enable source: counts 0..11, enable at terminal count
  always @(posedge ck) begin
    if (!div_mode) div_cnt <= 4'd0;
    else if (div_cnt == 4'd11) div_cnt <= 4'd0;
    else div_cnt <= div_cnt + 4'd1;
  end

  assign if_a.E  = div_mode ? (div_cnt == 4'd11) : e_drv;
  assign if_b.E  = div_mode ? (div_cnt == 4'd11) : e_drv;
  assign if_a.SE = se_drv;
  assign if_b.SE = se_drv;

  // Divide-by-2 enable for the cascaded cell, clocked by its own parent clock
  always @(posedge if_a.ECK or posedge tog_clr) begin
    if (tog_clr) tog <= 1'b0;
    else tog <= ~tog;
  end

  assign if_c.E  = tog;
  assign if_c.SE = 1'b0;

  // Pulse counters on each gated clock
  always @(posedge if_a.ECK) cnt_a <= cnt_a + 1;
  always @(posedge if_b.ECK) cnt_b <= cnt_b + 1;
  always @(posedge if_c.ECK) cnt_c <= cnt_c + 1;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Both modes must show the same expected ECK/EQ at this sample point
  task automatic applyStimulus(input string tag, input logic exp_eck, input logic exp_eq);
    checkOutput({tag, "_eck_m0"}, {31'd0, if_a.ECK}, {31'd0, exp_eck});
    checkOutput({tag, "_eq_m0"},  {31'd0, if_a.EQ},  {31'd0, exp_eq});
    checkOutput({tag, "_eck_m1"}, {31'd0, if_b.ECK}, {31'd0, exp_eck});
    checkOutput({tag, "_eq_m1"},  {31'd0, if_b.EQ},  {31'd0, exp_eq});
  endtask

  // Absolute time bound so the run always terminates
  initial begin
    #50000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with both enables high: gated clock stays off
    e_drv  = 1'b1;
    se_drv = 1'b1;
    repeat (3) begin
      @(posedge ck); #2 applyStimulus("rst_hi", 1'b0, 1'b0);
      @(negedge ck); #2 applyStimulus("rst_lo", 1'b0, 1'b0);
    end

    // Release mid-high: no partial pulse, first pulse on the next full high phase
    @(posedge ck); #2 rst = 1'b0;
    #1 applyStimulus("rel_hi", 1'b0, 1'b0);
    @(negedge ck); #2 applyStimulus("rel_lo", 1'b0, 1'b1);
    @(posedge ck); #2 applyStimulus("rel_first", 1'b1, 1'b1);

    // Static functional enable: 10 full pulses
    @(posedge ck); #1 e_drv = 1'b1; se_drv = 1'b0;
    base_a = cnt_a; base_b = cnt_b;
    repeat (10) begin
      @(posedge ck); #2 applyStimulus("en_hi", 1'b1, 1'b1);
      @(negedge ck); #2 applyStimulus("en_lo", 1'b0, 1'b1);
    end
    checkOutput("en_cnt_m0", cnt_a - base_a, 10);
    checkOutput("en_cnt_m1", cnt_b - base_b, 10);

    // Enables off: gated clock held low
    @(posedge ck); #1 e_drv = 1'b0;
    @(negedge ck); #2 applyStimulus("off_lo", 1'b0, 1'b0);
    base_a = cnt_a; base_b = cnt_b;
    repeat (5) begin
      @(posedge ck); #2 applyStimulus("off_hi", 1'b0, 1'b0);
    end
    checkOutput("off_cnt_m0", cnt_a - base_a, 0);
    checkOutput("off_cnt_m1", cnt_b - base_b, 0);

    // Scan override: 5 pulses with E low
    @(posedge ck); #1 se_drv = 1'b1;
    base_a = cnt_a; base_b = cnt_b;
    repeat (5) begin
      @(posedge ck); #2 applyStimulus("se_hi", 1'b1, 1'b1);
      @(negedge ck); #2 applyStimulus("se_lo", 1'b0, 1'b1);
    end
    checkOutput("se_cnt_m0", cnt_a - base_a, 5);
    checkOutput("se_cnt_m1", cnt_b - base_b, 5);

    // Drop SE: current phase completes, low phase clears, next edge is silent
    @(posedge ck); #1 se_drv = 1'b0;
    #1 applyStimulus("se_drop_hi", 1'b1, 1'b1);
    @(negedge ck); #2 applyStimulus("se_drop_lo", 1'b0, 1'b0);
    @(posedge ck); #2 applyStimulus("se_next", 1'b0, 1'b0);

    // E pulse entirely inside a high phase: no activity now or next cycle
    @(posedge ck); #1 e_drv = 1'b1;
    #2 e_drv = 1'b0;
    #1 applyStimulus("gl_hi", 1'b0, 1'b0);
    @(negedge ck); #2 applyStimulus("gl_lo", 1'b0, 1'b0);
    @(posedge ck); #2 applyStimulus("gl_next", 1'b0, 1'b0);

    // E raised mid-high and held: first pulse at the following edge, full width
    @(posedge ck); #2 e_drv = 1'b1;
    #1 applyStimulus("late_hi", 1'b0, 1'b0);
    @(negedge ck); #2 applyStimulus("late_lo", 1'b0, 1'b1);
    @(posedge ck); #1 applyStimulus("late_first_early", 1'b1, 1'b1);
    #3 applyStimulus("late_first_end", 1'b1, 1'b1);
    e_drv = 1'b0;
    @(negedge ck); #2 applyStimulus("late_off", 1'b0, 1'b0);

    // Divide-by-12 chain with cascaded divide-by-2 over 120 parent cycles
    tog_clr = 1'b0;
    @(posedge ck); #1 div_mode = 1'b1;
    base_a = cnt_a; base_b = cnt_b; base_c = cnt_c;
    repeat (120) @(posedge ck);
    #2;
    checkOutput("div12_m0", cnt_a - base_a, 10);
    checkOutput("div12_m1", cnt_b - base_b, 10);
    checkOutput("div24_casc", cnt_c - base_c, 5);

    // Asynchronous reset in the middle of an enabled pulse kills it at once
    @(posedge ck); #1 div_mode = 1'b0; e_drv = 1'b1;
    @(posedge ck); #2 applyStimulus("pre_arst", 1'b1, 1'b1);
    rst = 1'b1;
    #1 applyStimulus("arst_hi", 1'b0, 1'b0);
    @(negedge ck); #2 applyStimulus("arst_lo", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
